// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse
//
// Conditions one raw mechanical push-button for the LED matrix controller.
// The raw input is synchronized with a two-flop chain and then debounced by
// a stable-level counter. The block produces a debounced level plus clean
// single-cycle press/release pulses. Optional auto-repeat re-fires `pressed`
// while the key stays down, for stepping controls such as brightness.
//
// Parameters:
//   DEBOUNCE_CYCLES     stable synchronized samples needed to accept a change (>= 1)
//   REPEAT_EN           1 = auto-repeat on, 0 = off
//   REPEAT_DELAY_CYCLES cycles in DOWN before the first repeat pulse (>= 1)
//   REPEAT_RATE_CYCLES  cycles between subsequent repeat pulses (>= 1)
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   btn       raw button, asynchronous to clk, active-high, bouncy
//   level     debounced button state
//   pressed   one-cycle pulse on each accepted press and on each repeat
//   released  one-cycle pulse on each accepted release
//   held      high from the first repeat pulse until release
//
// States:
//   IDLE         | button up, waiting for a high sample
//   PRESS_WAIT   | qualifying a press; any low sample abandons it
//   DOWN         | press accepted; auto-repeat timing runs here
//   RELEASE_WAIT | qualifying a release; any high sample returns to DOWN

module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_EN           = 0,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pressed,
  output logic released,
  output logic held
);

  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    DOWN         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic          s1;
  logic          s2;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;
  logic          level_nxt;
  logic          pressed_nxt;
  logic          released_nxt;
  logic          held_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      rcnt     <= '0;
      level    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
      held     <= 1'b0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rcnt     <= rcnt_nxt;
      level    <= level_nxt;
      pressed  <= pressed_nxt;
      released <= released_nxt;
      held     <= held_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rcnt_nxt     = rcnt;
    level_nxt    = level;
    pressed_nxt  = 1'b0;
    released_nxt = 1'b0;
    held_nxt     = held;

    case (state)
      IDLE: begin
        if (s2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s2) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = DOWN;
          level_nxt   = 1'b1;
          pressed_nxt = 1'b1;
          rcnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      DOWN: begin
        if (!s2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (REPEAT_EN != 0) begin
          // First repeat waits the long delay, later ones use the rate.
          if (!held) begin
            if (rcnt == DELAY_LAST) begin
              pressed_nxt = 1'b1;
              held_nxt    = 1'b1;
              rcnt_nxt    = '0;
            end else begin
              rcnt_nxt = rcnt + RW'(1);
            end
          end else begin
            if (rcnt == RATE_LAST) begin
              pressed_nxt = 1'b1;
              rcnt_nxt    = '0;
            end else begin
              rcnt_nxt = rcnt + RW'(1);
            end
          end
        end
      end

      RELEASE_WAIT: begin
        // rcnt is left untouched here so a release glitch only pauses
        // the repeat timer instead of restarting it.
        if (s2) begin
          state_nxt = DOWN;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = IDLE;
          level_nxt    = 1'b0;
          released_nxt = 1'b1;
          held_nxt     = 1'b0;
          rcnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse
//
// Directed bench for btn_debounce_pulse. Three instances share btn/rst:
//   u_base  DEBOUNCE_CYCLES=4, no repeat
//   u_rep   DEBOUNCE_CYCLES=4, repeat on (delay 10, rate 3)
//   u_d1    DEBOUNCE_CYCLES=1, no repeat
// Edge index i in each scenario counts clock edges from the first edge that
// samples the new btn value; outputs are sampled 1 time unit after each edge.

module tb_btn_debounce_pulse;

  logic clk = 1'b0;
  logic rst;
  logic btn;

  logic b_level, b_pressed, b_released, b_held;
  logic r_level, r_pressed, r_released, r_held;
  logic d_level, d_pressed, d_released, d_held;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int e       = 0;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_RATE_CYCLES(3)
  ) u_base (
    .clk(clk), .rst(rst), .btn(btn),
    .level(b_level), .pressed(b_pressed), .released(b_released), .held(b_held)
  );

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_RATE_CYCLES(3)
  ) u_rep (
    .clk(clk), .rst(rst), .btn(btn),
    .level(r_level), .pressed(r_pressed), .released(r_released), .held(r_held)
  );

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(1), .REPEAT_EN(0),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_RATE_CYCLES(3)
  ) u_d1 (
    .clk(clk), .rst(rst), .btn(btn),
    .level(d_level), .pressed(d_pressed), .released(d_released), .held(d_held)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_base_rep(input string sc,
                              input logic bp, input logic bl, input logic br,
                              input logic rp, input logic rl, input logic rr,
                              input logic rh);
    chk({sc, "_base_pressed"},  b_pressed,  bp);
    chk({sc, "_base_level"},    b_level,    bl);
    chk({sc, "_base_released"}, b_released, br);
    chk({sc, "_base_held"},     b_held,     1'b0);
    chk({sc, "_rep_pressed"},   r_pressed,  rp);
    chk({sc, "_rep_level"},     r_level,    rl);
    chk({sc, "_rep_released"},  r_released, rr);
    chk({sc, "_rep_held"},      r_held,     rh);
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;

    // Reset state
    repeat (3) step();
    chk_base_rep("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_d1_level",    d_level,    1'b0);
    chk("reset_d1_pressed",  d_pressed,  1'b0);
    chk("reset_d1_released", d_released, 1'b0);
    chk("reset_d1_held",     d_held,     1'b0);
    rst = 1'b0;
    repeat (3) step();

    // Clean press, released before edge 20
    btn = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      e = i;
      if (i == 20) btn = 1'b0;
      step();
      chk_base_rep("clean",
                   (i == 6), (i >= 6 && i <= 25), (i == 26),
                   (i == 6 || i == 16 || i == 19), (i >= 6 && i <= 25), (i == 26),
                   (i >= 16 && i <= 25));
      chk("clean_d1_pressed",  d_pressed,  (i == 3));
      chk("clean_d1_level",    d_level,    (i >= 3 && i <= 22));
      chk("clean_d1_released", d_released, (i == 23));
      chk("clean_d1_held",     d_held,     1'b0);
    end
    repeat (5) step();

    // Bouncy press, then a 2-cycle glitch while down, then release at edge 26
    for (int i = 0; i <= 34; i++) begin
      e = i;
      btn = (i == 0) || (i == 2) || (i >= 4 && i <= 12) || (i >= 15 && i <= 25);
      step();
      chk_base_rep("bounce_glitch",
                   (i == 10), (i >= 10 && i <= 31), (i == 32),
                   (i == 10 || i == 23 || i == 26), (i >= 10 && i <= 31), (i == 32),
                   (i >= 23 && i <= 31));
    end
    repeat (5) step();

    // Auto-repeat, held 30 cycles
    for (int i = 0; i <= 40; i++) begin
      e = i;
      btn = (i < 30);
      step();
      chk_base_rep("repeat",
                   (i == 6), (i >= 6 && i <= 35), (i == 36),
                   (i == 6 || i == 16 || i == 19 || i == 22 || i == 25 ||
                    i == 28 || i == 31),
                   (i >= 6 && i <= 35), (i == 36),
                   (i >= 16 && i <= 35));
    end
    repeat (5) step();

    // Reset in PRESS_WAIT (edges 4-5), fresh press from edge 6,
    // then reset while DOWN at edge 15 with btn released
    for (int i = 0; i <= 24; i++) begin
      e = i;
      rst = (i == 4) || (i == 5) || (i == 15);
      btn = (i < 15);
      step();
      chk_base_rep("reset_mid",
                   (i == 12), (i >= 12 && i <= 14), 1'b0,
                   (i == 12), (i >= 12 && i <= 14), 1'b0,
                   1'b0);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Front-end conditioner for the mechanical push-buttons of the LED matrix controller. It synchronizes the raw asynchronous button input, debounces it with a stable-level counter, and emits clean single-cycle `pressed`/`released` event pulses plus a debounced level. It sits directly upstream of the toggle/mode-select logic that consumes `pressed`. An optional auto-repeat mode generates repeated `pressed` pulses while a key is held, for stepping controls such as brightness and scroll speed.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz). Must be ≥ 1.
- `REPEAT_EN`, default 0: enables auto-repeat. 1 = on, 0 = off. Toggle consumers keep this at 0.
- `REPEAT_DELAY_CYCLES`, default 50_000_000: cycles in DOWN before the first repeat pulse. Must be ≥ 1.
- `REPEAT_RATE_CYCLES`, default 10_000_000: cycles between subsequent repeat pulses. Must be ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `btn` in 1: raw button, asynchronous to `clk`, active-high, bouncy.
- `level` out 1: debounced button state.
- `pressed` out 1: one-cycle pulse on each accepted press and on each repeat.
- `released` out 1: one-cycle pulse on each accepted release.
- `held` out 1: high from the first repeat pulse until release. Stays 0 when `REPEAT_EN`=0.

## Operation
- **Synchronizer.** A two-flop chain `s1 <= btn`, `s2 <= s1`. Both flops reset to 0. All logic below uses `s2` only.
- **Debounce counter.** `cnt`, width `$clog2(DEBOUNCE_CYCLES)` (minimum 1 bit).
- **Repeat counter.** `rcnt`, width sized to max(`REPEAT_DELAY_CYCLES`, `REPEAT_RATE_CYCLES`).
- **FSM states:** IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT. Reset state is IDLE.
- **IDLE**
  - `s2`=1: go to PRESS_WAIT, `cnt`<=0.
- **PRESS_WAIT**
  - `s2`=0: go to IDLE. This is a bounce; no output.
  - `s2`=1 and `cnt`==DEBOUNCE_CYCLES-1: go to DOWN, `level`<=1, `pressed`<=1 for one cycle, `rcnt`<=0.
  - Otherwise: `cnt`++.
- **DOWN**
  - `s2`=0: go to RELEASE_WAIT, `cnt`<=0.
  - While `REPEAT_EN`=1 (evaluated only when `s2`=1):
    - `held`=0: `rcnt`++. When `rcnt`==REPEAT_DELAY_CYCLES-1, pulse `pressed`, set `held`<=1, `rcnt`<=0.
    - `held`=1: `rcnt`++. When `rcnt`==REPEAT_RATE_CYCLES-1, pulse `pressed`, `rcnt`<=0.
- **RELEASE_WAIT**
  - `s2`=1: return to DOWN. `rcnt` is frozen during RELEASE_WAIT and resumes counting.
  - `s2`=0 and `cnt`==DEBOUNCE_CYCLES-1: go to IDLE, `level`<=0, `released`<=1 for one cycle, `held`<=0, `rcnt`<=0.
  - Otherwise: `cnt`++.
- **Pulse rules.** `pressed` and `released` are registered and are never high in the same cycle. A pulse is never longer than one cycle.
- **Pulse rate.** With repeat enabled, consecutive `pressed` pulses are at least `REPEAT_RATE_CYCLES` cycles apart.
- **No wrap.** Counters never wrap. Every terminal compare causes a reset or a state change.

## Timing
- **Reset value.** All outputs are 0 on reset. `s1`, `s2`, `cnt` and `rcnt` are 0, and the state is IDLE.
- **Reset mid-operation.** Reset in any state returns to IDLE in the same cycle, with no `released` pulse. If `btn` is still high after `rst` deasserts, it is detected as a fresh press with full latency.
- **Press latency.** Let edge E be the first clock edge that samples `btn`=1, with `btn` held stable from then on. `level` and `pressed` go high on edge E+DEBOUNCE_CYCLES+2.
- **Release latency.** Symmetric: `level` falls and `released` pulses DEBOUNCE_CYCLES+2 edges after the first edge that samples `btn`=0.
- **Bounces.** Any sample of the opposite level during a WAIT state restarts qualification from zero.
- **First repeat pulse.** Occurs REPEAT_DELAY_CYCLES edges after the initial `pressed` edge, provided no RELEASE_WAIT time intervenes.
- **Subsequent repeats.** Each follows the previous one by REPEAT_RATE_CYCLES edges.
- **DEBOUNCE_CYCLES=1.** PRESS_WAIT and RELEASE_WAIT each last exactly one cycle. Latency is 3 edges.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3.
- **Clean press/release, REPEAT_EN=0.** `btn` rises before edge 0 and falls before edge 20 → `pressed` high only after edge 6; `level` high over edges 6–25; `released` high only after edge 26.
- **Bouncy press.** `btn` toggles 1,0,1,0 on successive cycles, then stays 1 → no `pressed` during the bounces; exactly one `pressed` 6 edges after the final rising sample.
- **Glitch while down.** `btn` held 1, then drops to 0 for 2 cycles → no `released`; `level` stays 1; no second `pressed`.
- **Auto-repeat, REPEAT_EN=1, held 30 cycles.** `pressed` at edges P, P+10, P+13, P+16, …; `held` high from P+10; `held` cleared together with the `released` pulse.
- **Reset mid-press.** `rst` pulsed while in PRESS_WAIT with `btn`=1 and held → all outputs 0 during reset; after `rst` deasserts, `pressed` asserts 6 edges after the first post-reset sampling edge.
- **Reset while DOWN.** `rst` asserted while DOWN → `level`=0 the next cycle, no `released` pulse, state IDLE.
